ml_multi_channel_interface: RTL and testbench

Successor to the single-channel ML front end. It captures accumulated I/Q pairs from N_CH readout channels, normalizes them (shift + signed saturation) into per-channel pending slots, and round-robin arbitrates them onto one shared nn_model core through the HLS ap_start/ap_ready/ap_done handshake. Each result is returned tagged with its channel index. The block adds per-channel overflow detection and a watchdog timeout on the NN core.

---
 rtl/ml_multi_channel_interface.sv | 245 ++++++++++++++++++++++++
 tb/tb_ml_multi_channel_interface.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_multi_channel_interface.sv
// Multi-channel ML front end.
// Captures I/Q pairs from N_CH readout channels, normalizes each word
// (arithmetic shift then signed saturation) into a per-channel pending slot,
// and round-robin arbitrates the slots onto one shared nn_model core using
// the HLS ap_start/ap_ready/ap_done handshake. Each result comes back tagged
// with its channel. A watchdog abandons NN jobs that never finish.
module ml_multi_channel_interface #(
    parameter int N_CH       = 4,
    parameter int IN_W       = 32,
    parameter int OUT_W      = 18,
    parameter int NORM_SHIFT = 8,
    parameter int TIMEOUT    = 1024,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          start_trigger,
    input  logic [N_CH*2*IN_W-1:0]   accumulated_data,
    output logic                     nn_start,
    output logic [2*OUT_W-1:0]       nn_data,
    input  logic                     nn_ready,
    input  logic                     nn_done,
    input  logic [OUT_W-1:0]         nn_prob,
    input  logic                     nn_state,
    output logic                     res_valid,
    output logic [CH_W-1:0]          res_ch,
    output logic [OUT_W-1:0]         res_prob,
    output logic                     res_state,
    output logic                     res_timeout,
    output logic [N_CH-1:0]          overflow,
    output logic                     busy
);

    localparam int PAIR_W = 2 * OUT_W;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    // Saturation bounds expressed at the shifted word width.
    localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] normalize(input logic [IN_W-1:0] word);
        logic signed [IN_W-1:0] shifted;
        shifted = $signed(word) >>> NORM_SHIFT;
        if (shifted > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end else begin
            return shifted[OUT_W-1:0];
        end
    endfunction

    state_t              r_state;
    state_t              w_nextState;
    logic [N_CH-1:0]     r_pending;
    logic [N_CH-1:0]     r_overflow;
    logic [PAIR_W-1:0]   r_slot [N_CH];
    logic [PAIR_W-1:0]   w_norm [N_CH];
    logic [CH_W-1:0]     r_rrPtr;
    logic [CH_W-1:0]     r_curCh;
    logic [CH_W-1:0]     w_grantCh;
    logic                w_found;
    logic                w_grantValid;
    logic [N_CH-1:0]     w_grantHit;
    logic                w_finish;
    logic                w_timeout;
    logic                w_wdogExpired;
    logic [WD_W-1:0]     r_wdog;
    logic                r_nnStart;
    logic [PAIR_W-1:0]   r_nnData;
    logic                r_resValid;
    logic [CH_W-1:0]     r_resCh;
    logic [OUT_W-1:0]    r_resProb;
    logic                r_resState;
    logic                r_resTimeout;

    // Normalized {Q, I} pair for every channel, ready to be captured.
    for (genvar c = 0; c < N_CH; c++) begin : g_norm
        assign w_norm[c] = {normalize(accumulated_data[c*2*IN_W+IN_W +: IN_W]),
                            normalize(accumulated_data[c*2*IN_W +: IN_W])};
    end

    assign w_wdogExpired = (r_wdog == WD_W'(TIMEOUT - 1));

    // Round-robin search: first pending channel after the last one granted.
    always_comb begin : p_rrSearch
        int idx;
        idx       = 0;
        w_grantCh = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(r_rrPtr) + k) % N_CH;
            if (!w_found && r_pending[idx]) begin
                w_found   = 1'b1;
                w_grantCh = CH_W'(idx);
            end
        end
    end

    // Next-state logic for the NN handshake plus grant/finish/timeout events.
    always_comb begin
        w_nextState  = r_state;
        w_grantValid = 1'b0;
        w_finish     = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grantValid = 1'b1;
                    w_nextState  = S_START;
                end
            end
            S_START: begin
                if (nn_ready && nn_done) begin
                    w_finish    = 1'b1;
                    w_nextState = S_IDLE;
                end else if (w_wdogExpired) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_IDLE;
                end else if (nn_ready) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (nn_done) begin
                    w_finish    = 1'b1;
                    w_nextState = S_IDLE;
                end else if (w_wdogExpired) begin
                    w_timeout   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // One-hot view of which slot is being granted this cycle.
    always_comb begin
        w_grantHit = '0;
        for (int c = 0; c < N_CH; c++) begin
            w_grantHit[c] = w_grantValid && (w_grantCh == CH_W'(c));
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Slot capture: a granted slot may be refilled in the same cycle; a full,
    // ungranted slot keeps its old sample and flags a sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_overflow <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_slot[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (start_trigger[c]) begin
                    if (!r_pending[c] || w_grantHit[c]) begin
                        r_slot[c]    <= w_norm[c];
                        r_pending[c] <= 1'b1;
                    end else begin
                        r_overflow[c] <= 1'b1;
                    end
                end else if (w_grantHit[c]) begin
                    r_pending[c] <= 1'b0;
                end
            end
        end
    end

    // NN request side: launch on grant, hold until ready, watchdog the job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nnStart <= 1'b0;
            r_nnData  <= '0;
            r_curCh   <= '0;
            r_rrPtr   <= CH_W'(N_CH - 1);
            r_wdog    <= '0;
        end else if (w_grantValid) begin
            r_nnStart <= 1'b1;
            r_nnData  <= r_slot[w_grantCh];
            r_curCh   <= w_grantCh;
            r_rrPtr   <= w_grantCh;
            r_wdog    <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_nextState == S_IDLE) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + WD_W'(1);
            end
            if (w_nextState != S_START) begin
                r_nnStart <= 1'b0;
            end
        end
    end

    // Result registers: one-cycle valid pulse, payload held between pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_resValid   <= 1'b0;
            r_resCh      <= '0;
            r_resProb    <= '0;
            r_resState   <= 1'b0;
            r_resTimeout <= 1'b0;
        end else begin
            r_resValid <= w_finish || w_timeout;
            if (w_finish) begin
                r_resCh      <= r_curCh;
                r_resProb    <= nn_prob;
                r_resState   <= nn_state;
                r_resTimeout <= 1'b0;
            end else if (w_timeout) begin
                r_resCh      <= r_curCh;
                r_resProb    <= '0;
                r_resState   <= 1'b0;
                r_resTimeout <= 1'b1;
            end
        end
    end

    assign nn_start    = r_nnStart;
    assign nn_data     = r_nnData;
    assign res_valid   = r_resValid;
    assign res_ch      = r_resCh;
    assign res_prob    = r_resProb;
    assign res_state   = r_resState;
    assign res_timeout = r_resTimeout;
    assign overflow    = r_overflow;
    assign busy        = (r_state != S_IDLE) || (|r_pending);

endmodule

// File: tb/tb_ml_multi_channel_interface.sv
// Testbench for ml_multi_channel_interface: directed scenarios plus randomized
// rounds, checked against a transaction-level model of slots and arbitration.
module tb_ml_multi_channel_interface;

    localparam int N_CH       = 4;
    localparam int IN_W       = 32;
    localparam int OUT_W      = 18;
    localparam int NORM_SHIFT = 8;
    localparam int TIMEOUT    = 16;
    localparam int CH_W       = 2;
    localparam longint MAXV   = longint'(2 ** (OUT_W - 1)) - 1;
    localparam longint MINV   = -longint'(2 ** (OUT_W - 1));

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         start_trigger;
    logic [N_CH*2*IN_W-1:0]  accumulated_data;
    logic                    nn_start;
    logic [2*OUT_W-1:0]      nn_data;
    logic                    nn_ready;
    logic                    nn_done;
    logic [OUT_W-1:0]        nn_prob;
    logic                    nn_state;
    logic                    res_valid;
    logic [CH_W-1:0]         res_ch;
    logic [OUT_W-1:0]        res_prob;
    logic                    res_state;
    logic                    res_timeout;
    logic [N_CH-1:0]         overflow;
    logic                    busy;

    int errors = 0;
    int checks = 0;

    logic [IN_W-1:0]      stimI [N_CH];
    logic [IN_W-1:0]      stimQ [N_CH];
    logic                 pendM [N_CH];
    logic [2*OUT_W-1:0]   slotM [N_CH];
    logic [N_CH-1:0]      ovM;
    int                   rrM;

    ml_multi_channel_interface #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W),
        .NORM_SHIFT(NORM_SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start_trigger(start_trigger),
        .accumulated_data(accumulated_data), .nn_start(nn_start), .nn_data(nn_data),
        .nn_ready(nn_ready), .nn_done(nn_done), .nn_prob(nn_prob), .nn_state(nn_state),
        .res_valid(res_valid), .res_ch(res_ch), .res_prob(res_prob), .res_state(res_state),
        .res_timeout(res_timeout), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] normM(input logic [IN_W-1:0] w);
        longint v;
        v = longint'($signed(w));
        v = v >>> NORM_SHIFT;
        if (v > MAXV) v = MAXV;
        if (v < MINV) v = MINV;
        return OUT_W'(v);
    endfunction

    function automatic logic [2*OUT_W-1:0] pairM(input int c);
        return {normM(stimQ[c]), normM(stimI[c])};
    endfunction

    function automatic int modelPick();
        int idx;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (rrM + k) % N_CH;
            if (pendM[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic bit anyPend();
        for (int c = 0; c < N_CH; c++) if (pendM[c]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [IN_W-1:0] rndWord();
        logic [IN_W-1:0] x;
        x = $urandom;
        case ($urandom_range(0, 2))
            0:       return x;
            1:       return IN_W'($signed(x) >>> 12);
            default: return IN_W'($signed(x) >>> 20);
        endcase
    endfunction

    task automatic randomizeStim();
        for (int c = 0; c < N_CH; c++) begin
            stimI[c] = rndWord();
            stimQ[c] = rndWord();
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < N_CH; c++) begin
            pendM[c] = 1'b0;
            slotM[c] = '0;
        end
        ovM = '0;
        rrM = N_CH - 1;
    endtask

    // Drive one cycle of triggers (caller ticks) and optionally update the model.
    task automatic applyStimulus(input logic [N_CH-1:0] mask, input bit modelIt);
        for (int c = 0; c < N_CH; c++) begin
            accumulated_data[c*2*IN_W +: 2*IN_W] = {stimQ[c], stimI[c]};
            if (modelIt && mask[c]) begin
                if (pendM[c]) ovM[c] = 1'b1;
                else begin
                    pendM[c] = 1'b1;
                    slotM[c] = pairM(c);
                end
            end
        end
        start_trigger = mask;
    endtask

    // Act as the NN core for one job and check the request and the result.
    task automatic serveJob(input int rdyDly, input int doneDly, input bit toJob,
                            input bit noReady, input logic [N_CH-1:0] burst);
        int n, elapsed, expCh, i;
        logic [OUT_W-1:0] p;
        logic s;
        logic [2*OUT_W-1:0] d;
        bit done;
        n = 0;
        while (nn_start !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checkOutput("grant_seen", nn_start, 1);
        if (nn_start !== 1'b1) return;
        expCh = modelPick();
        checkOutput("model_pending", 64'(expCh >= 0), 1);
        if (expCh < 0) return;
        d = slotM[expCh];
        checkOutput("nn_data", nn_data, d);
        checkOutput("busy_job", busy, 1);
        pendM[expCh] = 1'b0;
        rrM = expCh;
        elapsed = 0;
        done = 1'b0;
        p = '0;
        s = 1'b0;
        if (noReady) begin
            while (elapsed < TIMEOUT) begin
                tick();
                elapsed++;
                if (elapsed == TIMEOUT - 1) checkOutput("nn_start_hold_to", nn_start, 1);
            end
        end else begin
            for (int k = 0; k < rdyDly; k++) begin
                tick();
                elapsed++;
            end
            checkOutput("nn_start_hold", nn_start, 1);
            checkOutput("nn_data_hold", nn_data, d);
            nn_ready = 1'b1;
            if (!toJob && doneDly == 0) begin
                p = OUT_W'($urandom);
                s = 1'($urandom);
                nn_done = 1'b1;
                nn_prob = p;
                nn_state = s;
                done = 1'b1;
            end
            tick();
            elapsed++;
            nn_ready = 1'b0;
            nn_done  = 1'b0;
            nn_prob  = '0;
            nn_state = 1'b0;
            if (!done) begin
                checkOutput("nn_start_drop", nn_start, 0);
                i = 0;
                while (!done && elapsed < TIMEOUT) begin
                    if (i == 0 && burst != '0) applyStimulus(burst, 1'b1);
                    if (!toJob && i == doneDly - 1) begin
                        p = OUT_W'($urandom);
                        s = 1'($urandom);
                        nn_done = 1'b1;
                        nn_prob = p;
                        nn_state = s;
                        done = 1'b1;
                    end
                    tick();
                    elapsed++;
                    i++;
                    start_trigger = '0;
                    nn_done  = 1'b0;
                    nn_prob  = '0;
                    nn_state = 1'b0;
                end
            end
        end
        checkOutput("res_valid", res_valid, 1);
        checkOutput("res_ch", res_ch, expCh);
        checkOutput("res_timeout", res_timeout, !done);
        checkOutput("res_prob", res_prob, p);
        checkOutput("res_state", res_state, s);
        checkOutput("nn_start_end", nn_start, 0);
        tick();
        checkOutput("res_pulse", res_valid, 0);
        checkOutput("res_hold", res_prob, p);
    endtask

    initial begin
        logic [2*OUT_W-1:0] keep;
        int jobs;
        bit first;
        logic [N_CH-1:0] mask;
        rst = 1'b1;
        start_trigger = '0;
        accumulated_data = '0;
        nn_ready = 1'b0;
        nn_done = 1'b0;
        nn_prob = '0;
        nn_state = 1'b0;
        modelReset();

        // Reset values
        #2 rst = 1'b0;
        #3;
        checkOutput("rst_nn_start", nn_start, 0);
        checkOutput("rst_nn_data", nn_data, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_prob", res_prob, 0);
        checkOutput("rst_res_timeout", res_timeout, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // All four channels at once: served in order 0..3
        randomizeStim();
        applyStimulus(4'hF, 1'b1);
        tick();
        start_trigger = '0;
        checkOutput("all4_busy", busy, 1);
        for (int j = 0; j < N_CH; j++) begin
            serveJob(0, 2, 1'b0, 1'b0, '0);
            checkOutput("all4_order", res_ch, j);
        end
        checkOutput("all4_overflow", overflow, 0);

        // Channel 0 directed data and trigger-to-start latency
        stimI[0] = 32'h0001_2300;
        stimQ[0] = 32'hFFFF_FF00;
        applyStimulus(4'b0001, 1'b1);
        tick();
        start_trigger = '0;
        checkOutput("lat1_nn_start", nn_start, 0);
        checkOutput("lat1_busy", busy, 1);
        tick();
        checkOutput("lat2_nn_start", nn_start, 1);
        checkOutput("ch0_nn_data", nn_data, 36'hF_FFFC_0123);
        serveJob(1, 4, 1'b0, 1'b0, '0);
        checkOutput("ch0_res_ch", res_ch, 0);

        // Saturation on channel 2
        stimI[2] = 32'h7FFF_FFFF;
        stimQ[2] = 32'h8000_0000;
        applyStimulus(4'b0100, 1'b1);
        tick();
        start_trigger = '0;
        tick();
        checkOutput("sat_nn_data", nn_data, 36'h8_0001_FFFF);
        serveJob(1, 1, 1'b0, 1'b0, '0);

        // Overflow: channel 2 re-triggered while pending behind channel 3
        randomizeStim();
        applyStimulus(4'b1100, 1'b1);
        tick();
        start_trigger = '0;
        keep = slotM[2];
        randomizeStim();
        serveJob(1, 2, 1'b0, 1'b0, 4'b0100);
        checkOutput("ovf_flag", overflow, 4'b0100);
        checkOutput("ovf_first_kept", nn_data, keep);
        serveJob(0, 3, 1'b0, 1'b0, '0);
        checkOutput("ovf_res_ch", res_ch, 2);

        // Re-trigger in the grant cycle: old data to NN, new data kept, no overflow
        randomizeStim();
        applyStimulus(4'b0010, 1'b1);
        tick();
        stimI[1] = rndWord();
        stimQ[1] = rndWord();
        keep = pairM(1);
        applyStimulus(4'b0010, 1'b0);
        tick();
        start_trigger = '0;
        serveJob(0, 1, 1'b0, 1'b0, '0);
        pendM[1] = 1'b1;
        slotM[1] = keep;
        serveJob(2, 0, 1'b0, 1'b0, '0);
        checkOutput("regrant_overflow", overflow, 4'b0100);

        // Watchdog without ready, then the next pending channel is served
        randomizeStim();
        applyStimulus(4'b0011, 1'b1);
        tick();
        start_trigger = '0;
        serveJob(0, 0, 1'b1, 1'b1, '0);
        checkOutput("next_after_to", nn_start, 1);
        serveJob(0, 1, 1'b0, 1'b0, '0);

        // Watchdog after ready, then a stray done in IDLE is ignored
        randomizeStim();
        applyStimulus(4'b0001, 1'b1);
        tick();
        start_trigger = '0;
        serveJob(2, 0, 1'b1, 1'b0, '0);
        nn_done = 1'b1;
        nn_prob = 18'h155;
        tick();
        nn_done = 1'b0;
        nn_prob = '0;
        checkOutput("stray_done_valid", res_valid, 0);
        checkOutput("stray_done_busy", busy, 0);

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            mask = N_CH'($urandom_range(1, 15));
            randomizeStim();
            applyStimulus(mask, 1'b1);
            tick();
            start_trigger = '0;
            first = 1'b1;
            jobs = 0;
            while (anyPend() && jobs < 12) begin
                int rdy, dn;
                bit to, nr;
                logic [N_CH-1:0] b;
                rdy = $urandom_range(0, 3);
                dn  = $urandom_range(0, 5);
                to  = ($urandom_range(0, 5) == 0);
                nr  = to && ($urandom_range(0, 1) == 1);
                b   = first ? N_CH'($urandom_range(0, 15)) : '0;
                if (b != '0) randomizeStim();
                serveJob(rdy, dn, to, nr, b);
                first = 1'b0;
                jobs++;
            end
            checkOutput("rnd_overflow", overflow, ovM);
            checkOutput("rnd_busy_end", busy, 0);
        end

        // Reset in the middle of a job
        randomizeStim();
        applyStimulus(4'b1001, 1'b1);
        tick();
        start_trigger = '0;
        tick();
        checkOutput("midrst_started", nn_start, 1);
        nn_ready = 1'b1;
        tick();
        nn_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_nn_start", nn_start, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_overflow", overflow, 0);
        checkOutput("midrst_res_valid", res_valid, 0);
        tick();
        tick();
        rst = 1'b1;
        modelReset();
        nn_done = 1'b1;
        tick();
        nn_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checkOutput("midrst_no_result", res_valid, 0);
            tick();
        end
        checkOutput("midrst_idle", busy, 0);

        // Round-robin pointer restarts at channel 0 after reset
        randomizeStim();
        applyStimulus(4'b1010, 1'b1);
        tick();
        start_trigger = '0;
        serveJob(0, 1, 1'b0, 1'b0, '0);
        checkOutput("rr_after_rst", res_ch, 1);
        serveJob(0, 1, 1'b0, 1'b0, '0);
        checkOutput("rr_after_rst2", res_ch, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
